// File: rtl/corefifo_reset_seq_pkg.sv
// Shared definitions for the FIFO reset sequencer: the sequencer state
// encoding, a constant-foldable clog2 and the legal parameter ranges.
package corefifo_reset_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Legal parameter ranges, checked at elaboration by the modules.
   localparam int MIN_NUM_STAGES = 2;
   localparam int MIN_NUM_CH     = 1;
   localparam int MAX_NUM_CH     = 16;
   localparam int MIN_MIN_ASSERT = 1;
   localparam int MIN_GAP        = 1;

   // Channel index is wide enough to count one past the largest channel.
   localparam int CH_IDX_W = 5;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/corefifo_reset_seq_if.sv
// Channel-side bundle of the reset sequencer: enables in, resets and status
// out. The abort counter exists only when CORESEQ_ABORT_CNT_EN is defined.
interface corefifo_reset_seq_if #(
   parameter int NUM_CH = 3
);
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] reset_out;
   logic              busy;
   logic              seq_done;
`ifdef CORESEQ_ABORT_CNT_EN
   logic [7:0]        abort_cnt;

   modport master (
      input  ch_en,
      output reset_out, busy, seq_done, abort_cnt
   );
   modport slave (
      output ch_en,
      input  reset_out, busy, seq_done, abort_cnt
   );
`else
   modport master (
      input  ch_en,
      output reset_out, busy, seq_done
   );
   modport slave (
      output ch_en,
      input  reset_out, busy, seq_done
   );
`endif
endinterface

// File: rtl/corefifo_reset_seq_sync.sv
// N-stage single-bit synchroniser with a synchronous clear that forces every
// stage to 0.
module corefifo_sync_bit
   import corefifo_reset_seq_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clear,
   input  logic d,
   output logic q
);

   if (STAGES < MIN_NUM_STAGES) begin : g_param_err
      $error("corefifo_sync_bit: STAGES must be at least 2");
   end

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk) begin
      if (clear) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/corefifo_reset_seq.sv
// Multi-channel reset sequencer for the FIFO control domain.
// Synchronises the active-low request, holds every channel in reset for
// MIN_ASSERT cycles, then releases channels in index order GAP cycles apart.
// Optional feature macro: CORESEQ_ABORT_CNT_EN (adds the 8-bit abort_cnt).
module corefifo_reset_seq
   import corefifo_reset_seq_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int NUM_CH     = 3,
   parameter int MIN_ASSERT = 4,
   parameter int GAP        = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rst_req_n,
   corefifo_reset_seq_if.master bus
);

   localparam int MAX_CNT = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
   localparam int CNT_W   = clog2(MAX_CNT) + 1;

   if (NUM_STAGES < MIN_NUM_STAGES || NUM_CH < MIN_NUM_CH || NUM_CH > MAX_NUM_CH ||
       MIN_ASSERT < MIN_MIN_ASSERT || GAP < MIN_GAP) begin : g_param_err
      $error("corefifo_reset_seq: parameter out of range");
   end

   logic                sync_q;
   logic                req_s;
   state_t              state;
   state_t              state_nx;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nx;
   logic [CH_IDX_W-1:0] ch_idx;
   logic [CH_IDX_W-1:0] ch_idx_nx;
   logic [NUM_CH-1:0]   rel;
   logic [NUM_CH-1:0]   rel_nx;
   logic                busy_r;
   logic                done_r;

   corefifo_sync_bit #(
      .STAGES (NUM_STAGES)
   ) u_sync (
      .clk   (clk),
      .clear (reset),
      .d     (rst_req_n),
      .q     (sync_q)
   );

   // Registered, active-high view of the request so the FSM decodes a clean
   // flop output; reset reads as "request asserted".
   always_ff @(posedge clk) begin
      if (reset) begin
         req_s <= 1'b1;
      end else begin
         req_s <= ~sync_q;
      end
   end

   // Next-state, counter, channel index and release-mask decode.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ch_idx_nx = ch_idx;
      // A channel whose enable is low is forced back into reset every cycle.
      rel_nx    = rel & bus.ch_en;
      if (req_s) begin
         state_nx  = ASSERT;
         cnt_nx    = '0;
         ch_idx_nx = '0;
         rel_nx    = '0;
      end else begin
         case (state)
            ASSERT: begin
               if (cnt == CNT_W'(MIN_ASSERT - 1)) begin
                  state_nx  = RELEASE;
                  cnt_nx    = '0;
                  ch_idx_nx = '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt == CNT_W'(GAP - 1)) begin
                  // A disabled channel still uses its slot but stays in reset.
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (ch_idx == CH_IDX_W'(i)) begin
                        rel_nx[i] = bus.ch_en[i];
                     end
                  end
                  cnt_nx    = '0;
                  ch_idx_nx = ch_idx + CH_IDX_W'(1);
                  if (ch_idx == CH_IDX_W'(NUM_CH - 1)) begin
                     state_nx = DONE;
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state_nx = DONE;
            end
            default: begin
               state_nx  = ASSERT;
               cnt_nx    = '0;
               ch_idx_nx = '0;
               rel_nx    = '0;
            end
         endcase
      end
   end

   // State register plus registered channel resets and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ASSERT;
         cnt    <= '0;
         ch_idx <= '0;
         rel    <= '0;
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         ch_idx <= ch_idx_nx;
         rel    <= rel_nx;
         busy_r <= (state_nx != DONE);
         done_r <= (state_nx == DONE);
      end
   end

   assign bus.reset_out = rel;
   assign bus.busy      = busy_r;
   assign bus.seq_done  = done_r;

`ifdef CORESEQ_ABORT_CNT_EN
   logic       abort;
   logic [7:0] abort_cnt_r;

   // An abort only counts when it interrupts a release in progress or done.
   assign abort = req_s && (state != ASSERT);

   // Saturating count of aborts out of RELEASE or DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         abort_cnt_r <= 8'd0;
      end else if (abort && (abort_cnt_r != 8'hFF)) begin
         abort_cnt_r <= abort_cnt_r + 8'd1;
      end
   end

   assign bus.abort_cnt = abort_cnt_r;
`endif

endmodule

// File: tb/tb_corefifo_reset_seq.sv
// Self-checking bench for corefifo_reset_seq with a timing-formula model.
module tb_corefifo_reset_seq;

   localparam int NS     = 2;
   localparam int NCH    = 3;
   localparam int MA     = 4;
   localparam int GP     = 2;
   localparam int K_DONE = MA + NCH * GP;

   logic clk;
   logic reset;
   logic rst_req_n;

   corefifo_reset_seq_if #(.NUM_CH(NCH)) bus ();

   corefifo_reset_seq #(
      .NUM_STAGES (NS),
      .NUM_CH     (NCH),
      .MIN_ASSERT (MA),
      .GAP        (GP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rst_req_n (rst_req_n),
      .bus       (bus)
   );

   int checks   = 0;
   int failures = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural model: the request reaches the sequencer NS+1 edges after
   // it is sampled; k counts consecutive edges it has been seen deasserted.
   // Channel i releases when k == MA + (i+1)*GP, the sequence is done once
   // k >= MA + NCH*GP.
   bit             dl[$];
   int             k = 0;
   logic [NCH-1:0] m_rel = '0;
   bit             m_busy = 1'b1;
   bit             m_done = 1'b0;
   int             m_abort = 0;
   bit             model_ok = 1'b0;

   task automatic model_step(input bit rst_i, input bit req_i, input logic [NCH-1:0] en);
      bit eff;
      int k_prev;
      eff = dl.pop_front();
      dl.push_back(req_i && !rst_i);
      k_prev = k;
      if (rst_i) begin
         foreach (dl[j]) dl[j] = 1'b0;
         k       = 0;
         m_rel   = '0;
         m_abort = 0;
      end else if (!eff) begin
         if (k_prev >= MA && m_abort < 255) m_abort++;
         k     = 0;
         m_rel = '0;
      end else begin
         if (k < 1000000) k++;
         for (int i = 0; i < NCH; i++) begin
            if (k == MA + (i + 1) * GP) m_rel[i] = en[i];
         end
         m_rel = m_rel & en;
      end
      m_done = (k >= K_DONE);
      m_busy = !m_done;
   endtask

   // Per-cycle comparison of the DUT against the model.
   initial begin
      for (int j = 0; j < NS + 1; j++) dl.push_back(1'b0);
      forever begin
         @(posedge clk);
         model_step(reset, rst_req_n, bus.ch_en);
         if (reset) model_ok = 1'b1;
         #1;
         if (model_ok) begin
            check("model_reset_out", 32'(bus.reset_out), 32'(m_rel));
            check("model_busy", 32'(bus.busy), 32'(m_busy));
            check("model_seq_done", 32'(bus.seq_done), 32'(m_done));
`ifdef CORESEQ_ABORT_CNT_EN
            check("model_abort_cnt", 32'(bus.abort_cnt), 32'(m_abort));
`endif
         end
      end
   end

   // Edge bookkeeping relative to T0: after to_edge(e) we sit at the falling
   // edge that follows rising edge T0+e.
   int cur = -1;

   task automatic to_edge(input int e);
      while (cur < e) begin
         @(posedge clk);
         cur++;
      end
      @(negedge clk);
   endtask

   task automatic outs(input string name, input logic [NCH-1:0] ro, input bit b, input bit d);
      check({name, "_reset_out"}, 32'(bus.reset_out), 32'(ro));
      check({name, "_busy"}, 32'(bus.busy), 32'(b));
      check({name, "_seq_done"}, 32'(bus.seq_done), 32'(d));
   endtask

   initial begin
      int unsigned r;
      reset     = 1'b1;
      rst_req_n = 1'b0;
      bus.ch_en = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs("reset_state", 3'b000, 1'b1, 1'b0);

      // Release sequence from T0.
      reset = 1'b0; rst_req_n = 1'b1; cur = -1;
      to_edge(7);  outs("rel_e7", 3'b000, 1'b1, 1'b0);
      to_edge(8);  outs("rel_e8", 3'b001, 1'b1, 1'b0);
      check("model_pin_e8", 32'(m_rel), 32'h1);
      to_edge(10); outs("rel_e10", 3'b011, 1'b1, 1'b0);
      to_edge(11); outs("rel_e11", 3'b011, 1'b1, 1'b0);
      to_edge(12); outs("rel_e12", 3'b111, 1'b0, 1'b1);
      check("model_pin_e12", 32'({m_done, m_rel}), 32'hF);

      // Mid-sequence abort, then a clean repeat.
      rst_req_n = 1'b0; to_edge(18);
      outs("abort_idle", 3'b000, 1'b1, 1'b0);
      rst_req_n = 1'b1; cur = -1;
      to_edge(8);  outs("abort_e8", 3'b001, 1'b1, 1'b0);
      rst_req_n = 1'b0;
      to_edge(10); outs("abort_e10", 3'b011, 1'b1, 1'b0);
      to_edge(12); outs("abort_e12", 3'b000, 1'b1, 1'b0);
      rst_req_n = 1'b1; cur = -1;
      to_edge(8);  outs("repeat_e8", 3'b001, 1'b1, 1'b0);
      to_edge(12); outs("repeat_e12", 3'b111, 1'b0, 1'b1);

      // Disabled channel keeps its slot but stays in reset.
      rst_req_n = 1'b0; to_edge(18);
      bus.ch_en = 3'b101; rst_req_n = 1'b1; cur = -1;
      to_edge(10); outs("dis_e10", 3'b001, 1'b1, 1'b0);
      to_edge(12); outs("dis_e12", 3'b101, 1'b0, 1'b1);
      bus.ch_en = 3'b111;
      to_edge(14); outs("dis_reen", 3'b101, 1'b0, 1'b1);

      // Disable after release, then re-enable.
      rst_req_n = 1'b0; to_edge(20);
      rst_req_n = 1'b1; cur = -1;
      to_edge(12); outs("post_e12", 3'b111, 1'b0, 1'b1);
      bus.ch_en = 3'b110;
      to_edge(13); outs("post_dis", 3'b110, 1'b0, 1'b1);
      bus.ch_en = 3'b111;
      to_edge(15); outs("post_reen", 3'b110, 1'b0, 1'b1);

      // Master reset in DONE with the request still released.
      reset = 1'b1;
      to_edge(16); outs("mrst_hold", 3'b000, 1'b1, 1'b0);
      reset = 1'b0; cur = -1;
      to_edge(7);  outs("mrst_e7", 3'b000, 1'b1, 1'b0);
      to_edge(8);  outs("mrst_e8", 3'b001, 1'b1, 1'b0);

      // Randomised request, enable and reset traffic.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         if (rst_req_n && r < 4) rst_req_n = 1'b0;
         else if (!rst_req_n && r < 30) rst_req_n = 1'b1;
         if ($urandom_range(0, 99) < 3) bus.ch_en = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      reset = 1'b0; rst_req_n = 1'b1; bus.ch_en = 3'b111;

`ifdef CORESEQ_ABORT_CNT_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 300; n++) begin
         rst_req_n = 1'b1;
         repeat (16) @(posedge clk);
         @(negedge clk);
         rst_req_n = 1'b0;
         @(negedge clk);
      end
      rst_req_n = 1'b1;
      repeat (14) @(posedge clk);
      @(negedge clk);
      check("abort_cnt_sat", 32'(bus.abort_cnt), 32'd255);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cnt_clr", 32'(bus.abort_cnt), 32'd0);
      reset = 1'b0;
`endif

      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
